// File: rtl/a2d_pkg.sv
// a2d_pkg: shared state encoding and command constants for the A2D channel arbiter
package a2d_pkg;
    typedef enum logic [1:0] {IDLE, CMD_WT, GAP, RD_WT} arb_state_t;
    localparam int NUM_REQ = 4;
    localparam logic [10:0] A2D_CMD_PAD = 11'h000;
endpackage

// File: rtl/a2d_chnl_arb_rr_pick4.sv
// rr_pick4: combinational round-robin picker, first set req bit at or above ptr with wrap
module rr_pick4
    import a2d_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [1:0]         idx,
    output logic               any
);
    logic [NUM_REQ-1:0] w_rot;
    logic [1:0]         w_off;
    // Rotating the doubled vector puts the pointer position at bit 0
    assign w_rot = 4'({req, req} >> ptr);
    assign w_off = w_rot[0] ? 2'd0 : w_rot[1] ? 2'd1 : w_rot[2] ? 2'd2 : 2'd3;
    assign idx   = ptr + w_off;
    assign any   = |req;
endmodule

// File: rtl/a2d_chnl_arb.sv
// a2d_chnl_arb: round-robin arbiter sharing one SPI engine among four A2D requesters.
// Optional SPI done timeout enabled by defining A2D_ARB_TIMEOUT_EN.
module a2d_chnl_arb
    import a2d_pkg::*;
#(
    parameter logic [11:0] CHNL_MAP = 12'o4310
`ifdef A2D_ARB_TIMEOUT_EN
    , parameter int TO_CYC = 4096
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REQ-1:0]  req,
    output logic [NUM_REQ-1:0]  cmplt,
    output logic [11:0]         rslt,
    output logic                busy,
    output logic                snd,
    output logic [15:0]         cmd,
    input  logic                done,
    input  logic [15:0]         resp,
    output logic                err
);
    arb_state_t         r_state, w_state_nxt;
    logic [1:0]         r_ptr, w_ptr_nxt, r_gnt, w_gnt_nxt, w_pick;
    logic [15:0]        r_cmd, w_cmd_nxt;
    logic [NUM_REQ-1:0] r_cmplt, w_cmplt_nxt;
    logic [11:0]        r_rslt, w_rslt_nxt;
    logic               r_snd, w_snd_nxt, r_busy, w_busy_nxt, r_err, w_err_nxt;
    logic               w_any, w_to;
    logic               w_unused_resp;

    assign w_unused_resp = ^resp[15:12];

    rr_pick4 u_pick (
        .req (req),
        .ptr (r_ptr),
        .idx (w_pick),
        .any (w_any)
    );

`ifdef A2D_ARB_TIMEOUT_EN
    logic [12:0] r_to_cnt;
    logic        w_wait;
    assign w_wait = (r_state == CMD_WT) || (r_state == RD_WT);
    assign w_to   = w_wait && !done && (r_to_cnt == 13'(TO_CYC - 1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_to_cnt <= '0;
        else if (w_snd_nxt)
            r_to_cnt <= '0;
        else if (w_wait)
            r_to_cnt <= r_to_cnt + 13'd1;
    end
`else
    assign w_to = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = r_gnt;
        w_cmd_nxt   = r_cmd;
        w_snd_nxt   = 1'b0;
        w_busy_nxt  = r_busy;
        w_cmplt_nxt = '0;
        w_rslt_nxt  = r_rslt;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: if (w_any) begin
                w_gnt_nxt   = w_pick;
                w_cmd_nxt   = {2'b00, CHNL_MAP[3*int'(w_pick) +: 3], A2D_CMD_PAD};
                w_snd_nxt   = 1'b1;
                w_busy_nxt  = 1'b1;
                w_state_nxt = CMD_WT;
            end
            CMD_WT: if (done) begin
                w_state_nxt = GAP;
            end else if (w_to) begin
                w_err_nxt   = 1'b1;
                w_busy_nxt  = 1'b0;
                w_ptr_nxt   = r_gnt + 2'd1;
                w_state_nxt = IDLE;
            end
            GAP: begin
                w_snd_nxt   = 1'b1;
                w_state_nxt = RD_WT;
            end
            RD_WT: if (done) begin
                w_rslt_nxt  = resp[11:0];
                w_cmplt_nxt = 4'b0001 << r_gnt;
                w_busy_nxt  = 1'b0;
                w_ptr_nxt   = r_gnt + 2'd1;
                w_state_nxt = IDLE;
            end else if (w_to) begin
                w_err_nxt   = 1'b1;
                w_busy_nxt  = 1'b0;
                w_ptr_nxt   = r_gnt + 2'd1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_cmd   <= '0;
            r_snd   <= 1'b0;
            r_busy  <= 1'b0;
            r_cmplt <= '0;
            r_rslt  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= w_gnt_nxt;
            r_cmd   <= w_cmd_nxt;
            r_snd   <= w_snd_nxt;
            r_busy  <= w_busy_nxt;
            r_cmplt <= w_cmplt_nxt;
            r_rslt  <= w_rslt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign cmplt = r_cmplt;
    assign rslt  = r_rslt;
    assign busy  = r_busy;
    assign snd   = r_snd;
    assign cmd   = r_cmd;
    assign err   = r_err;
endmodule

// File: tb/tb_a2d_chnl_arb.sv
// tb_a2d_chnl_arb: directed self-checking bench for a2d_chnl_arb (default build, no timeout)
module tb_a2d_chnl_arb;
    logic        clk, rst, done, snd, busy, err;
    logic [3:0]  req, cmplt;
    logic [11:0] rslt;
    logic [15:0] cmd, resp;
    int          n_cmp, n_fail;
    logic [15:0] cmd_tab [4];

    a2d_chnl_arb dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .cmplt (cmplt),
        .rslt  (rslt),
        .busy  (busy),
        .snd   (snd),
        .cmd   (cmd),
        .done  (done),
        .resp  (resp),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Snd must appear exactly one cycle after the triggering edge
    task automatic wait_snd(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!snd && n < 8);
        chk(tag, n, 1);
    endtask

    task automatic convert(input logic [3:0] r, input int idx, input logic [15:0] rv);
        req = r;
        wait_snd("snd1_lat");
        chk("snd1_cmd", cmd, cmd_tab[idx]);
        chk("snd1_busy", busy, 1);
        repeat (10) tick();
        chk("cw_snd_low", snd, 0);
        chk("cw_cmd_stable", cmd, cmd_tab[idx]);
        repeat (9) tick();
        done = 1'b1;
        resp = 16'hF00D;
        tick();
        done = 1'b0;
        wait_snd("snd2_lat");
        chk("snd2_cmd", cmd, cmd_tab[idx]);
        repeat (19) tick();
        chk("rd_busy", busy, 1);
        done = 1'b1;
        resp = rv;
        tick();
        done = 1'b0;
        chk("cmplt", cmplt, 32'(4'b0001 << idx));
        chk("rslt", rslt, 32'(rv[11:0]));
        chk("busy_drop", busy, 0);
        chk("err_low", err, 0);
    endtask

    initial begin
        cmd_tab = '{16'h0000, 16'h0800, 16'h1800, 16'h2000};
        n_cmp = 0;
        n_fail = 0;
        clk = 0;
        rst = 1;
        req = 0;
        done = 0;
        resp = 0;
        repeat (3) tick();
        chk("rst_cmplt", cmplt, 0);
        chk("rst_rslt", rslt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_snd", snd, 0);
        chk("rst_cmd", cmd, 0);
        chk("rst_err", err, 0);
        rst = 0;
        tick();

        convert(4'b0001, 0, 16'h0ABC);
        req = 4'b0000;
        tick();
        chk("cmplt_strobe", cmplt, 0);
        chk("idle_snd", snd, 0);
        chk("idle_busy", busy, 0);
        chk("rslt_hold", rslt, 12'hABC);

        convert(4'b1000, 3, 16'h5123);
        req = 4'b0000;
        tick();
        convert(4'b0100, 2, 16'h0456);
        req = 4'b0000;
        tick();

        convert(4'b1011, 3, 16'h0333);
        convert(4'b1011, 0, 16'h0444);
        req = 4'b0000;
        tick();

        req = 4'b0100;
        wait_snd("rst_snd1_lat");
        chk("rst_snd1_cmd", cmd, 16'h1800);
        repeat (19) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        wait_snd("rst_snd2_lat");
        repeat (5) tick();
        req = 4'b0000;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_snd", snd, 0);
        chk("arst_cmd", cmd, 0);
        chk("arst_rslt", rslt, 0);
        chk("arst_cmplt", cmplt, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("arst_no_cmplt", cmplt, 0);
        convert(4'b0010, 1, 16'h0777);
        req = 4'b0000;
        tick();

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) convert(4'b1111, i % 4, 16'h0100 + 16'(i));
        req = 4'b0000;
        repeat (2) tick();

        done = 1'b1;
        resp = 16'hFFFF;
        tick();
        done = 1'b0;
        chk("stray_busy", busy, 0);
        chk("stray_snd", snd, 0);
        chk("stray_cmplt", cmplt, 0);
        chk("stray_rslt", rslt, 12'h107);
        tick();
        chk("stray_snd2", snd, 0);
        convert(4'b0010, 1, 16'h0999);
        req = 4'b0000;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
